// File: rtl/urv_defs.sv
// rtl/urv_defs.sv - shared RISC-V divide funct3 codes and operand constants
package urv_defs;

    localparam logic [2:0]  FUNC_DIV   = 3'b100;
    localparam logic [2:0]  FUNC_DIVU  = 3'b101;
    localparam logic [2:0]  FUNC_REM   = 3'b110;
    localparam logic [2:0]  FUNC_REMU  = 3'b111;

    localparam logic [31:0] INT_MIN_C  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES_C = 32'hFFFF_FFFF;

endpackage

// File: rtl/urv_div_ctrl_pkg.sv
// rtl/urv_div_ctrl_pkg.sv - state, classification and cache types for the divide controller
package urv_div_ctrl_pkg;

    import urv_defs::*;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } div_state_e;

    typedef enum logic [1:0] {
        CLS_ENGINE,
        CLS_DIV0,
        CLS_OVF,
        CLS_HIT
    } div_class_e;

    typedef struct packed {
        logic [31:0] n;
        logic [31:0] d;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
    } div_cache_t;

    function automatic logic fun_is_signed(input logic [2:0] fun);
        return (fun == FUNC_DIV) || (fun == FUNC_REM);
    endfunction

    function automatic logic fun_sel_rem(input logic [2:0] fun);
        return !((fun == FUNC_DIV) || (fun == FUNC_DIVU));
    endfunction

endpackage

// File: rtl/urv_div_classify.sv
// rtl/urv_div_classify.sv - special-case and result-cache compare for an incoming divide request
module urv_div_classify
    import urv_defs::*;
    import urv_div_ctrl_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic [2:0]  fun_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        cache_valid_i,
    input  div_cache_t  cache_i,
    output div_class_e  cls_o,
    output logic [31:0] data_o
);

    logic sgn;
    logic sel_rem;

    always_comb begin
        sgn     = fun_is_signed(fun_i);
        sel_rem = fun_sel_rem(fun_i);
        cls_o   = CLS_ENGINE;
        data_o  = '0;
        if (rs2_i == '0) begin
            cls_o  = CLS_DIV0;
            data_o = sel_rem ? rs1_i : ALL_ONES_C;
        end else if (sgn && (rs1_i == INT_MIN_C) && (rs2_i == ALL_ONES_C)) begin
            cls_o  = CLS_OVF;
            data_o = sel_rem ? 32'd0 : INT_MIN_C;
        end else if (CACHE_EN && cache_valid_i && (cache_i.n == rs1_i) &&
                     (cache_i.d == rs2_i) && (cache_i.sgn == sgn)) begin
            // One entry holds both q and r, so DIV after REM on the same operands hits too
            cls_o  = CLS_HIT;
            data_o = sel_rem ? cache_i.r : cache_i.q;
        end
    end

endmodule

// File: rtl/urv_div_ctrl.sv
// rtl/urv_div_ctrl.sv - divide request controller: special cases, result cache, engine handshake
module urv_div_ctrl
    import urv_defs::*;
    import urv_div_ctrl_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_fun_i,
    input  logic [31:0] req_rs1_i,
    input  logic [31:0] req_rs2_i,
    input  logic        kill_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        eng_start_o,
    output logic        eng_abort_o,
    output logic        eng_signed_o,
    output logic [31:0] eng_n_o,
    output logic [31:0] eng_d_o,
    input  logic        eng_done_i,
    input  logic [31:0] eng_q_i,
    input  logic [31:0] eng_r_i
);

    div_state_e  state_q, state_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        eng_signed_q, eng_signed_d;
    logic [31:0] eng_n_q, eng_n_d;
    logic [31:0] eng_d_q, eng_d_d;
    logic        sel_rem_q, sel_rem_d;
    div_cache_t  cache_q, cache_d;
    logic        cache_valid_q, cache_valid_d;

    div_class_e  cls;
    logic [31:0] cls_data;
    logic        accept;
    logic        start;
    logic        abort;

    urv_div_classify #(
        .CACHE_EN (CACHE_EN)
    ) u_classify (
        .fun_i         (req_fun_i),
        .rs1_i         (req_rs1_i),
        .rs2_i         (req_rs2_i),
        .cache_valid_i (cache_valid_q),
        .cache_i       (cache_q),
        .cls_o         (cls),
        .data_o        (cls_data)
    );

    assign req_ready_o = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o && !kill_i && !rst_i;

    always_comb begin
        state_d       = state_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        eng_signed_d  = eng_signed_q;
        eng_n_d       = eng_n_q;
        eng_d_d       = eng_d_q;
        sel_rem_d     = sel_rem_q;
        cache_d       = cache_q;
        cache_valid_d = cache_valid_q;
        start         = 1'b0;
        abort         = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_BUSY: begin
                if (kill_i) begin
                    abort   = !rst_i;
                    state_d = ST_IDLE;
                end else if (eng_done_i) begin
                    rsp_data_d    = sel_rem_q ? eng_r_i : eng_q_i;
                    rsp_valid_d   = 1'b1;
                    cache_d.n     = eng_n_q;
                    cache_d.d     = eng_d_q;
                    cache_d.sgn   = eng_signed_q;
                    cache_d.q     = eng_q_i;
                    cache_d.r     = eng_r_i;
                    cache_valid_d = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (kill_i || rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Acceptance overrides the RESP hand-off so back-to-back requests keep streaming
        if (accept) begin
            if (cls == CLS_ENGINE) begin
                start        = 1'b1;
                eng_signed_d = fun_is_signed(req_fun_i);
                eng_n_d      = req_rs1_i;
                eng_d_d      = req_rs2_i;
                sel_rem_d    = fun_sel_rem(req_fun_i);
                rsp_valid_d  = 1'b0;
                state_d      = ST_BUSY;
            end else begin
                rsp_data_d  = cls_data;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            eng_signed_q  <= 1'b0;
            eng_n_q       <= '0;
            eng_d_q       <= '0;
            sel_rem_q     <= 1'b0;
            cache_q       <= '0;
            cache_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            eng_signed_q  <= eng_signed_d;
            eng_n_q       <= eng_n_d;
            eng_d_q       <= eng_d_d;
            sel_rem_q     <= sel_rem_d;
            cache_q       <= cache_d;
            cache_valid_q <= cache_valid_d;
        end
    end

    // Operands are shown live in the start cycle so the engine can sample them with the pulse
    assign eng_start_o  = start;
    assign eng_abort_o  = abort;
    assign eng_signed_o = start ? fun_is_signed(req_fun_i) : eng_signed_q;
    assign eng_n_o      = start ? req_rs1_i : eng_n_q;
    assign eng_d_o      = start ? req_rs2_i : eng_d_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;

endmodule
